// File: rtl/ee354_2048_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_2048_pkg
//  Description : Shared definitions for the 2048 game blocks: move one-hot
//                encoding, move-issuer state encoding and parameter defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package ee354_2048_pkg;

    // One-hot move encoding, bit order {up, down, left, right}
    localparam logic [3:0] MOVE_UP    = 4'b1000;
    localparam logic [3:0] MOVE_DOWN  = 4'b0100;
    localparam logic [3:0] MOVE_LEFT  = 4'b0010;
    localparam logic [3:0] MOVE_RIGHT = 4'b0001;
    localparam logic [3:0] MOVE_NONE  = 4'b0000;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int REPEAT_CYCLES_DEFAULT   = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_REARM = 2'd3
    } issuer_state_t;

    // Fixed-priority pick among simultaneous requests: up > down > left > right
    function automatic logic [3:0] pick_move(input logic [3:0] req);
        if (req[3])      return MOVE_UP;
        else if (req[2]) return MOVE_DOWN;
        else if (req[1]) return MOVE_LEFT;
        else if (req[0]) return MOVE_RIGHT;
        else             return MOVE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ee354_move_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_move_issuer_if
//  Description : Move-command link between the move issuer (master) and the
//                2048 game FSM (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ee354_move_issuer_if;
    logic up;
    logic down;
    logic left;
    logic right;
    logic busy;
    logic q_Wait;
    logic game_over;

    modport master (
        output up, down, left, right, busy,
        input  q_Wait, game_over
    );

    modport slave (
        input  up, down, left, right, busy,
        output q_Wait, game_over
    );
endinterface
`default_nettype wire

// File: rtl/ee354_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_debounce
//  Description : Two-flop synchronizer, stability counter, debounced level
//                and single-cycle rising-edge pulse for one raw button.
//  Revision    : 1.0 - initial release
// ============================================================================
module ee354_debounce
    import ee354_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_rise
);

    // Level toggles on the cycle the counter would reach DEBOUNCE_CYCLES
    localparam logic [15:0] c_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  r_sync;
    logic [15:0] r_cnt;
    logic        r_level;
    logic        r_level_d;

    // Synchronize, count consecutive disagreeing samples, flip level when stable
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/ee354_move_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_move_issuer
//  Description : Debounces the four push-buttons, arbitrates simultaneous
//                presses and issues one registered move pulse per press while
//                the game FSM waits. Optional auto-repeat on a held button is
//                enabled by defining MOVE_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ee354_move_issuer
    import ee354_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    input  wire logic         BtnU,
    input  wire logic         BtnD,
    input  wire logic         BtnL,
    input  wire logic         BtnR,
    ee354_move_issuer_if.master mv
);

    logic [3:0]    w_raw;
    logic [3:0]    w_level;
    logic [3:0]    w_rise;
    logic [3:0]    w_win;
    logic          w_any_level;

    issuer_state_t r_state;
    logic [3:0]    r_dir;
    logic [3:0]    r_move;
    logic          r_busy;

    assign w_raw = {BtnU, BtnD, BtnL, BtnR};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        ee354_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .Clk     (Clk),
            .Reset   (Reset),
            .i_btn   (w_raw[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    assign w_win       = pick_move(w_rise);
    assign w_any_level = |w_level;

`ifdef MOVE_REPEAT_EN
    localparam logic [19:0] c_REPEAT_LAST = 20'(REPEAT_CYCLES - 1);

    logic        w_dir_held;
    logic [19:0] r_hold;

    // Only the button that produced the latched move can keep it repeating
    assign w_dir_held = |(w_level & r_dir);
`else
    // Without auto-repeat the hold time has no effect
    if (REPEAT_CYCLES < 1) begin : g_repeat_unused
    end
`endif

    // Issuer FSM: capture request, wait for game FSM, pulse once, re-arm
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_dir   <= MOVE_NONE;
            r_move  <= MOVE_NONE;
            r_busy  <= 1'b0;
`ifdef MOVE_REPEAT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_move <= MOVE_NONE;
            case (r_state)
                ST_IDLE: begin
                    if ((|w_rise) && !mv.game_over) begin
                        r_dir   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (mv.game_over) begin
                        r_dir   <= MOVE_NONE;
                        r_state <= ST_REARM;
                    end else if (mv.q_Wait) begin
                        r_move  <= r_dir;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_REARM;
`ifdef MOVE_REPEAT_EN
                    r_hold  <= '0;
`endif
                end
                ST_REARM: begin
`ifdef MOVE_REPEAT_EN
                    if (w_dir_held) begin
                        if (r_hold == c_REPEAT_LAST) begin
                            r_hold  <= '0;
                            r_state <= ST_PEND;
                        end else begin
                            r_hold <= r_hold + 20'd1;
                        end
                    end else begin
                        r_hold <= '0;
                        if (!w_any_level) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
`else
                    if (!w_any_level) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mv.up    = r_move[3];
    assign mv.down  = r_move[2];
    assign mv.left  = r_move[1];
    assign mv.right = r_move[0];
    assign mv.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ee354_move_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ee354_move_issuer
//  Description : Self-checking bench for ee354_move_issuer. Each press is
//                predicted from the timing rules: debounced rise 2+D edges
//                after the raw rise, pulse at max(4+D, first q_Wait-high
//                edge), busy from 3+D until 3+D edges after release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ee354_move_issuer;
    import ee354_2048_pkg::*;

    localparam int D = 4;
    localparam int R = 10;
`ifdef MOVE_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    logic BtnU, BtnD, BtnL, BtnR;
    int   n_checks = 0;
    int   n_fail   = 0;

    ee354_move_issuer_if mif();

    ee354_move_issuer #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .BtnU  (BtnU),
        .BtnD  (BtnD),
        .BtnL  (BtnL),
        .BtnR  (BtnR),
        .mv    (mif.master)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] obs();
        return {mif.up, mif.down, mif.left, mif.right, mif.busy};
    endfunction

    task automatic chk(input string tag, input int r, input logic [4:0] o, input logic [4:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s r=%0d: observed {u,d,l,r,busy}=%b expected %b", tag, r, o, e);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        {BtnU, BtnD, BtnL, BtnR} = m;
    endtask

    // Highest-priority button of a mask, as a one-hot move
    function automatic logic [3:0] winner(input logic [3:0] m);
        for (int i = 3; i >= 0; i--)
            if (m[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One press: optional short bounces, then mask held for h cycles.
    // q_Wait is low from the press until edge n (n=0: always high).
    // mode 0/1 normal, 2 game_over held throughout, 3 game_over rises in PEND.
    task automatic press_txn(input string tag, input logic [3:0] mask, input int nb,
                             input int n, input int h, input int mode);
        int p, plast, bstart, bend, last;
        logic [3:0] win;
        bit   pulse_exp;
        for (int b = 0; b < nb; b++) begin
            set_btn(mask);
            repeat ($urandom_range(1, D - 1)) begin tick(); chk(tag, -1, obs(), 5'b0); end
            set_btn(4'b0000);
            repeat ($urandom_range(1, 3)) begin tick(); chk(tag, -1, obs(), 5'b0); end
        end
        set_btn(mask);
        mif.q_Wait    = (n == 0);
        mif.game_over = (mode == 2);
        win   = winner(mask);
        p     = imax(4 + D, n + 1);
        plast = p;
        while (REPEAT_ON && plast + R + 2 <= h + 3 + D) plast += R + 2;
        bstart = (mode == 2) ? 1 << 30 : 3 + D;
        bend   = (mode == 3) ? imax(6 + D, h + 3 + D) : imax(plast + 2, h + 3 + D);
        last   = imax(bend, h + 3 + D) + 3;
        for (int r = 1; r <= last; r++) begin
            tick();
            pulse_exp = (mode < 2) && r >= p && r <= plast && ((r - p) % (R + 2)) == 0;
            chk(tag, r, obs(), {pulse_exp ? win : 4'b0000, (r >= bstart && r < bend)});
            if (r == n) mif.q_Wait = 1'b1;
            if (r == h) set_btn(4'b0000);
            if (mode == 3 && r == 4 + D) mif.game_over = 1'b1;
        end
        mif.game_over = 1'b0;
        mif.q_Wait    = 1'b1;
    endtask

    initial begin
        int mode, nwait, hold;
        Reset = 1'b1;
        set_btn(4'b0000);
        mif.q_Wait    = 1'b1;
        mif.game_over = 1'b0;
        tick();
        tick();
        chk("reset_state", 0, obs(), 5'b0);
        Reset = 1'b0;
        repeat (3) tick();
        chk("after_reset", 0, obs(), 5'b0);

        press_txn("clean_up", MOVE_UP, 0, 0, 20, 0);
        press_txn("bounce_left", MOVE_LEFT, 2, 0, 20, 0);
        press_txn("handshake_right", MOVE_RIGHT, 0, 26, 40, 0);
        press_txn("game_over_idle", MOVE_UP, 0, 0, 15, 2);
        press_txn("game_over_pend", MOVE_LEFT, 0, D + 12, 20, 3);

        // Down and right together; right held after down released
        set_btn(4'b0101);
        for (int r = 1; r <= 60; r++) begin
            tick();
            chk("simul_down", r, obs(), {(r == 4 + D) ? MOVE_DOWN : MOVE_NONE,
                                         (r >= 3 + D && r < 43 + D)});
            if (r == 12) set_btn(4'b0001);
            if (r == 40) set_btn(4'b0000);
        end
        press_txn("repress_right", MOVE_RIGHT, 0, 0, 12, 0);

        // Reset while a move is pending: busy clears at once, move is lost
        mif.q_Wait = 1'b0;
        set_btn(MOVE_UP);
        repeat (3 + D + 2) tick();
        chk("pend_before_reset", 0, obs(), 5'b00001);
        #2 Reset = 1'b1;
        #1 chk("async_reset", 0, obs(), 5'b0);
        set_btn(4'b0000);
        mif.q_Wait = 1'b1;
        repeat (3) begin tick(); chk("in_reset", 0, obs(), 5'b0); end
        Reset = 1'b0;
        for (int r = 1; r <= 20; r++) begin
            tick();
            chk("post_reset", r, obs(), 5'b0);
        end

`ifdef MOVE_REPEAT_EN
        // Hold up for 40 cycles after the first pulse: repeats every R+2
        set_btn(MOVE_UP);
        for (int r = 1; r <= 4 + D + 40 + D + 6; r++) begin
            tick();
            chk("repeat_up", r, obs(),
                {(r >= 4 + D && r <= 4 + D + 40 + 3 + D && ((r - (4 + D)) % (R + 2)) == 0)
                     ? MOVE_UP : MOVE_NONE,
                 (r >= 3 + D && r < 4 + D + 40 + 3 + D)});
            if (r == 4 + D + 40) set_btn(4'b0000);
        end
`endif

        for (int k = 0; k < 12; k++) begin
            mode  = $urandom_range(0, 3);
            hold  = $urandom_range(D + 1, 40);
            if (mode == 3) nwait = D + 8 + $urandom_range(0, 10);
            else           nwait = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30);
            press_txn("random", 4'($urandom_range(1, 15)), $urandom_range(0, 2), nwait, hold, mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ee354_move_issuer.md
# ee354_move_issuer

Front end that turns the four raw push-buttons into clean, single-cycle move commands (up, down, left, right) for the 2048 game state machine. It synchronizes and debounces each button, arbitrates simultaneous presses, and issues at most one move per press, only while the game FSM reports its WAIT state. It is the transmitting end of the move-command interface that the game FSM receives.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to change a debounced level; legal range 1..65535.
- REPEAT_CYCLES, default 1000: hold time before auto-repeat. Used only with MOVE_REPEAT_EN.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- BtnU, BtnD, BtnL, BtnR  in  1 each  raw, asynchronous, active-high buttons.
- q_Wait  in  1  high while the game FSM is in WAIT and able to accept a move.
- game_over  in  1  high while the game FSM is in WIN or LOSE.
- up, down, left, right  out  1 each  registered move pulses. At most one is high in any cycle.
- busy  out  1  high from request capture until the issuer returns to IDLE.

## Operation
- Per button:
  - 2-flop synchronizer.
  - 16-bit counter. It clears whenever the synchronized level equals the debounced level, and increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- A request is a rising edge of a debounced level.
- Priority among requests raised in the same cycle: up > down > left > right. Lower-priority requests in that cycle are discarded.
- FSM states: IDLE, PEND, ISSUE, REARM.
  - IDLE: on any request with game_over low, latch the winning direction and go to PEND. Requests arriving while game_over is high are discarded.
  - PEND: when q_Wait is high, go to ISSUE. If game_over rises, drop the latched direction and go to REARM.
  - ISSUE: assert the latched output for exactly one cycle, then go to REARM.
  - REARM: wait until all four debounced levels are low, then go to IDLE. New edges seen in REARM are ignored.
- Reset values:
  - up, down, left, right, busy = 0.
  - FSM in IDLE.
  - Debounced levels, synchronizers and counters all 0.
- Reset asserted mid-operation clears all outputs immediately, since the reset is asynchronous. Any pending move is lost and never issued.

## Timing
- Raw button rise at edge 0, held stable, q_Wait high, FSM in IDLE:
  - debounced level rises at edge 2+DEBOUNCE_CYCLES;
  - state is PEND after edge 3+DEBOUNCE_CYCLES;
  - the move output is high for the cycle following edge 4+DEBOUNCE_CYCLES.
- If q_Wait is low, PEND holds indefinitely. The output asserts in the cycle after the first edge at which q_Wait is sampled high.
- busy rises with entry to PEND and falls on entry to IDLE.
- Bounces shorter than DEBOUNCE_CYCLES samples produce no change in the debounced level.

## Configuration
- MOVE_REPEAT_EN defined:
  - In REARM, a 20-bit hold counter runs while the originating button's debounced level stays high.
  - When the counter reaches REPEAT_CYCLES, the FSM returns to PEND with the same direction and the counter clears.
  - Releasing the button returns the FSM to normal REARM behavior.
- MOVE_REPEAT_EN undefined: no hold counter exists, and exactly one move is issued per press.

## Structure
- Shared package ee354_2048_pkg holds:
  - the move one-hot encoding: MOVE_UP=4'b1000, MOVE_DOWN=4'b0100, MOVE_LEFT=4'b0010, MOVE_RIGHT=4'b0001;
  - the issuer state encodings;
  - the DEBOUNCE_CYCLES default.
- Sub-module ee354_debounce (synchronizer, counter, debounced level, rise pulse) is instantiated four times.

## Test plan
Unless noted otherwise, DEBOUNCE_CYCLES=4 and q_Wait is held at 1.
- Clean press: BtnU rises at edge 0 and is held. Required: up=1 for exactly the cycle after edge 8, no other output pulses, busy returns to 0 only after BtnU is released.
- Bounce: BtnL toggles 1,0,1,0 with 2-cycle periods, then goes stable high. Required: a single left pulse, 8 cycles after the stable rise.
- Simultaneous press: BtnD and BtnR rise on the same edge. Required: only down pulses. Holding BtnR after releasing BtnD produces no right pulse until BtnR is released and pressed again.
- Handshake: q_Wait held 0 for 20 cycles after debounce. Required: busy=1 and no pulse during that time; right pulses in the cycle after q_Wait returns to 1.
- game_over and reset: press with game_over=1 gives no pulse. In a second run, Reset asserted while in PEND clears busy at once, and no pulse appears after Reset falls.
- With MOVE_REPEAT_EN and REPEAT_CYCLES=10, holding BtnU for 40 cycles after its first pulse gives repeat up pulses spaced 12 cycles apart.
